adc_spi_reader: RTL and testbench

Reads one sample from the 18-bit two's-complement ADC on request. The block sits directly upstream of `control_loop`. It receives that loop's `adc_arm` / `adc_conv` request, pulses the ADC CONVERT pin, waits for the conversion, and clocks the result in over a read-only SPI link. It then presents `measured_value` with a level-held `finished` handshake.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/spi_shift_in.sv | 61 ++++++
 rtl/adc_spi_reader.sv | 116 +++++++++++
 tb/tb_adc_spi_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared ADC timing defaults and FSM state encoding for the ADC, DAC and loop blocks.
package adc_pkg;

    localparam int ADC_WID_DEF    = 18;
    localparam int CONV_HIGH_DEF  = 2;
    localparam int CONV_WAIT_DEF  = 70;
    localparam int SCK_HALF_DEF   = 2;
    localparam int TIMER_WID_DEF  = 8;
    localparam int BITCNT_WID_DEF = 5;

    localparam int STATE_WID = 3;

    typedef enum logic [STATE_WID-1:0] {
        ST_IDLE       = 3'd0,
        ST_CONV_PULSE = 3'd1,
        ST_CONV_WAIT  = 3'd2,
        ST_SHIFT      = 3'd3,
        ST_DONE       = 3'd4
    } adc_state_t;

endpackage

// File: rtl/spi_shift_in.sv
// Read-only SPI receiver: divides clk into SCK, counts bits and shifts miso in MSB first.
module spi_shift_in
    import adc_pkg::*;
#(
    parameter int ADC_WID    = ADC_WID_DEF,
    parameter int SCK_HALF   = SCK_HALF_DEF,
    parameter int TIMER_WID  = TIMER_WID_DEF,
    parameter int BITCNT_WID = BITCNT_WID_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               miso,
    output logic               sck,
    output logic               done,
    output logic [ADC_WID-1:0] data
);

    logic                  busy;
    logic [TIMER_WID-1:0]  half_cnt;
    logic [BITCNT_WID-1:0] bit_cnt;
    logic                  half_end;

    assign half_end = (half_cnt == TIMER_WID'(SCK_HALF - 1));

    // Done coincides with the falling edge that ends the trailing low-going half of the last bit.
    assign done = busy && half_end && sck && (bit_cnt == BITCNT_WID'(ADC_WID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            sck      <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            data     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            sck      <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
        end else if (stop) begin
            busy     <= 1'b0;
            sck      <= 1'b0;
            half_cnt <= '0;
        end else if (busy) begin
            if (half_end) begin
                half_cnt <= '0;
                sck      <= ~sck;
                // Sample on the rising SCK transition; miso was updated by the ADC well before.
                if (!sck) begin
                    data    <= {data[ADC_WID-2:0], miso};
                    bit_cnt <= bit_cnt + BITCNT_WID'(1);
                end
            end else begin
                half_cnt <= half_cnt + TIMER_WID'(1);
            end
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// Single-sample ADC reader: CONVERT pulse, conversion wait, SPI read and a level-held result handshake.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int ADC_WID    = ADC_WID_DEF,
    parameter int CONV_HIGH  = CONV_HIGH_DEF,
    parameter int CONV_WAIT  = CONV_WAIT_DEF,
    parameter int SCK_HALF   = SCK_HALF_DEF,
    parameter int TIMER_WID  = TIMER_WID_DEF,
    parameter int BITCNT_WID = BITCNT_WID_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      conv,
    output logic signed [ADC_WID-1:0] measured_value,
    output logic                      finished,
    output logic                      adc_conv_pin,
    output logic                      sck,
    output logic                      cs_n,
    input  logic                      miso
);

    adc_state_t            state_q, state_d;
    logic [TIMER_WID-1:0]  timer_q, timer_d;
    logic                  spi_start, spi_stop, spi_done;
    logic [ADC_WID-1:0]    spi_data;

    assign spi_start = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    assign spi_stop  = (state_q == ST_SHIFT) && (state_d != ST_SHIFT);

    spi_shift_in #(
        .ADC_WID    (ADC_WID),
        .SCK_HALF   (SCK_HALF),
        .TIMER_WID  (TIMER_WID),
        .BITCNT_WID (BITCNT_WID)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .start (spi_start),
        .stop  (spi_stop),
        .miso  (miso),
        .sck   (sck),
        .done  (spi_done),
        .data  (spi_data)
    );

    // Dropping arm anywhere between IDLE and DONE abandons the transaction.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (arm && !finished) begin
                    timer_d = '0;
                    state_d = conv ? ST_CONV_PULSE : ST_SHIFT;
                end
            end
            ST_CONV_PULSE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_WID'(CONV_HIGH - 1)) begin
                    state_d = ST_CONV_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_WID'(1);
                end
            end
            ST_CONV_WAIT: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_WID'(CONV_WAIT - 1)) begin
                    state_d = ST_SHIFT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_WID'(1);
                end
            end
            ST_SHIFT: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (spi_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are registered from the next state so they change on the very edge that enters a state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            adc_conv_pin   <= 1'b0;
            cs_n           <= 1'b1;
            finished       <= 1'b0;
            measured_value <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            adc_conv_pin <= (state_d == ST_CONV_PULSE);
            cs_n         <= (state_d != ST_SHIFT);
            finished     <= (state_d == ST_DONE);
            if (state_q == ST_SHIFT && state_d == ST_DONE) begin
                measured_value <= spi_data;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Randomised self-checking bench for adc_spi_reader against a transaction-level timing/value model.
module tb_adc_spi_reader;

    localparam int ADC_WID   = 18;
    localparam int CONV_HIGH = 2;
    localparam int CONV_WAIT = 70;
    localparam int SCK_HALF  = 2;
    localparam int LIMIT     = 400;

    logic                      clk;
    logic                      rst;
    logic                      arm;
    logic                      conv;
    logic signed [ADC_WID-1:0] measured_value;
    logic                      finished;
    logic                      adc_conv_pin;
    logic                      sck;
    logic                      cs_n;
    logic                      miso;

    int tests_run = 0;
    int tests_failed = 0;

    logic [ADC_WID-1:0]        adc_sample;
    int                        rise_idx;
    logic signed [ADC_WID-1:0] last_value;

    adc_spi_reader dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .conv           (conv),
        .measured_value (measured_value),
        .finished       (finished),
        .adc_conv_pin   (adc_conv_pin),
        .sck            (sck),
        .cs_n           (cs_n),
        .miso           (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: presents the MSB when selected and the next bit after each SCK rise.
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) rise_idx = 0;
        else      rise_idx = rise_idx + 1;
    end

    assign miso = (!cs_n && rise_idx < ADC_WID) ? adc_sample[ADC_WID-1-rise_idx] : 1'b0;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One full transaction; arm is raised at a negedge so the following posedge is E0.
    task automatic applyStimulus(input logic c, input logic [ADC_WID-1:0] sample,
                                 input int hold, input int gap);
        int   k, conv_cycles, conv_first, rises, first_rise, extra_act, lost;
        int   exp_fin, exp_rise;
        logic prev_sck;
        adc_sample = sample;
        conv = c;
        arm = 1'b1;
        exp_fin  = (c ? CONV_HIGH + CONV_WAIT : 0) + 2 * SCK_HALF * ADC_WID;
        exp_rise = (c ? CONV_HIGH + CONV_WAIT : 0) + SCK_HALF;
        conv_cycles = 0; conv_first = -1; rises = 0; first_rise = -1; prev_sck = 1'b0;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (adc_conv_pin) begin
                conv_cycles++;
                if (conv_first < 0) conv_first = k;
            end
            if (sck && !prev_sck) begin
                rises++;
                if (first_rise < 0) first_rise = k;
            end
            prev_sck = sck;
            if (finished) break;
        end
        checkOutput("finish_cycle", k, exp_fin);
        checkOutput("conv_cycles", conv_cycles, c ? CONV_HIGH : 0);
        checkOutput("conv_first", conv_first, c ? 0 : -1);
        checkOutput("first_sck_rise", first_rise, exp_rise);
        checkOutput("sck_rises", rises, ADC_WID);
        checkOutput("value", measured_value, $signed(sample));
        checkOutput("cs_n_at_done", cs_n, 1);
        last_value = $signed(sample);
        extra_act = 0; lost = 0;
        repeat (hold) begin
            @(negedge clk);
            if (adc_conv_pin || sck || !cs_n) extra_act++;
            if (!finished) lost++;
        end
        checkOutput("held_activity", extra_act, 0);
        checkOutput("held_finished_lost", lost, 0);
        arm = 1'b0;
        @(negedge clk);
        checkOutput("finished_fall", finished, 0);
        checkOutput("value_kept", measured_value, $signed(sample));
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic applyAbort(input int drop_at);
        int seen;
        adc_sample = ADC_WID'($urandom);
        conv = 1'b1;
        arm = 1'b1;
        repeat (drop_at + 1) @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        checkOutput("abort_sck", sck, 0);
        checkOutput("abort_cs_n", cs_n, 1);
        checkOutput("abort_conv_pin", adc_conv_pin, 0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (finished || !cs_n || sck) seen++;
        end
        checkOutput("abort_quiet", seen, 0);
        checkOutput("abort_value", measured_value, last_value);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; conv = 1'b0; adc_sample = '0; last_value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_value", measured_value, 0);
        checkOutput("rst_finished", finished, 0);
        checkOutput("rst_conv_pin", adc_conv_pin, 0);
        checkOutput("rst_sck", sck, 0);
        checkOutput("rst_cs_n", cs_n, 1);

        applyStimulus(1'b1, 18'h20001, 3, 1);
        checkOutput("neg_full_scale", measured_value, -131071);
        applyStimulus(1'b0, 18'h1FFFF, 2, 1);
        checkOutput("pos_full_scale", measured_value, 131071);

        applyAbort(80);

        applyStimulus(1'b1, 18'h0ABCD, 50, 2);

        // Reset in the middle of a conversion wait.
        adc_sample = 18'h15555; conv = 1'b1; arm = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_value", measured_value, 0);
        checkOutput("midrst_finished", finished, 0);
        checkOutput("midrst_conv_pin", adc_conv_pin, 0);
        checkOutput("midrst_sck", sck, 0);
        checkOutput("midrst_cs_n", cs_n, 1);
        arm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_value = '0;
        @(negedge clk);
        applyStimulus(1'b1, 18'h15555, 1, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2), (i % 2 == 0) ? 18'h00000 : 18'h3FFFF, 0, 1);
            checkOutput("alt_value", measured_value, (i % 2 == 0) ? 0 : -1);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ADC_WID'($urandom),
                          $urandom_range(0, 5), $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
